// File: rtl/fsm_tx_ctrl_pkg.sv
// Shared definitions for the UART transmit/receive memory controllers.
package fsm_tx_ctrl_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    SEND_LO = 3'd3,
    WAIT_LO = 3'd4,
    SEND_HI = 3'd5,
    WAIT_HI = 3'd6,
    FINISH  = 3'd7
  } tx_state_t;

endpackage

// File: rtl/fsm_tx_ctrl.sv
// Reads a block of words from vector memory and streams each one to the UART
// transmitter as a low byte followed by a zero-padded high byte.
module fsm_tx_ctrl
  import fsm_tx_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_words,
  output logic              busy,
  output logic              done,
  output logic              mem_read_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              tx_start,
  output logic [BYTE_W-1:0] tx_data,
  input  logic              tx_done
);

  tx_state_t         state;
  tx_state_t         state_next;
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W-1:0] addr_next;
  logic [ADDR_W-1:0] rem_cnt;
  logic [ADDR_W-1:0] rem_next;
  logic [DATA_W-1:0] word_reg;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and counter update; tx_done only matters in the two wait states
  always_comb begin
    state_next = state;
    addr_next  = addr_cnt;
    rem_next   = rem_cnt;
    case (state)
      IDLE: begin
        if (start) begin
          addr_next  = base_addr;
          rem_next   = num_words;
          state_next = (num_words == ADDR_W'(0)) ? FINISH : RD_REQ;
        end
      end
      RD_REQ:  state_next = RD_WAIT;
      RD_WAIT: state_next = SEND_LO;
      SEND_LO: state_next = WAIT_LO;
      WAIT_LO: begin
        if (tx_done) begin
          state_next = SEND_HI;
        end
      end
      SEND_HI: state_next = WAIT_HI;
      WAIT_HI: begin
        if (tx_done) begin
          if (rem_cnt == ADDR_W'(1)) begin
            state_next = FINISH;
          end else begin
            addr_next  = addr_cnt + ADDR_W'(1);
            rem_next   = rem_cnt - ADDR_W'(1);
            state_next = RD_REQ;
          end
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Registered outputs, aligned so strobes are high during their own state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_cnt    <= '0;
      rem_cnt     <= '0;
      word_reg    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_read_en <= 1'b0;
      mem_addr    <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
    end else begin
      addr_cnt    <= addr_next;
      rem_cnt     <= rem_next;
      busy        <= (state_next != IDLE);
      done        <= (state == FINISH);
      mem_read_en <= (state_next == RD_REQ);
      tx_start    <= (state_next == SEND_LO) || (state_next == SEND_HI);
      if (state_next == RD_REQ) begin
        mem_addr <= addr_next;
      end
      // Read data is only valid in RD_WAIT, so the low byte is taken straight from it
      if (state == RD_WAIT) begin
        word_reg <= mem_read_data;
        tx_data  <= mem_read_data[BYTE_W-1:0];
      end
      if ((state == WAIT_LO) && tx_done) begin
        tx_data <= BYTE_W'(word_reg[DATA_W-1:BYTE_W]);
      end
    end
  end

endmodule

// File: tb/tb_fsm_tx_ctrl.sv
// Directed bench for fsm_tx_ctrl with a registered memory model and a fixed-delay UART model.
module tb_fsm_tx_ctrl;

  localparam int unsigned DATA_W   = 10;
  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned UART_DLY = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] num_words = '0;
  logic              busy;
  logic              done;
  logic              mem_read_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_read_data;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_done;
  logic              uart_done;
  logic              stray_done = 1'b0;

  int checks = 0;
  int failures = 0;

  fsm_tx_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_words(num_words),
    .busy(busy), .done(done), .mem_read_en(mem_read_en), .mem_addr(mem_addr),
    .mem_read_data(mem_read_data), .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  assign tx_done = uart_done | stray_done;

  // Memory with one-cycle read latency
  logic [DATA_W-1:0] mem [0:1023];
  always @(posedge clk) begin
    if (mem_read_en) mem_read_data <= mem[mem_addr];
  end

  // UART: raises tx_done UART_DLY cycles after tx_start; flags protocol violations
  int   uart_cnt = 0;
  logic [7:0] uart_byte = '0;
  int   overlap_err = 0;
  int   stable_err = 0;
  always @(posedge clk) begin
    uart_done <= 1'b0;
    if (tx_start) begin
      if (uart_cnt != 0) overlap_err <= overlap_err + 1;
      uart_byte <= tx_data;
      uart_cnt  <= UART_DLY;
    end else if (uart_cnt != 0) begin
      if (!rst && tx_data !== uart_byte) stable_err <= stable_err + 1;
      uart_cnt <= uart_cnt - 1;
      if (uart_cnt == 1) uart_done <= 1'b1;
    end
  end

  // Transaction monitor
  logic [ADDR_W-1:0] rd_addrs[$];
  logic [7:0]        tx_bytes[$];
  int cyc = 0;
  int done_cnt = 0;
  int busy_cnt = 0;
  int start_cyc = -1;
  int first_tx_cyc = -1;
  int done_cyc = -1;
  logic clr_req = 1'b0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (clr_req) begin
      rd_addrs.delete();
      tx_bytes.delete();
      done_cnt     <= 0;
      busy_cnt     <= 0;
      start_cyc    <= -1;
      first_tx_cyc <= -1;
      done_cyc     <= -1;
    end else begin
      if (mem_read_en) rd_addrs.push_back(mem_addr);
      if (tx_start) tx_bytes.push_back(tx_data);
      if (tx_start && first_tx_cyc < 0) first_tx_cyc <= cyc;
      if (start) start_cyc <= cyc;
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (busy) busy_cnt <= busy_cnt + 1;
    end
  end

  task automatic clear_logs();
    @(negedge clk);
    clr_req = 1'b1;
    @(posedge clk);
    #1 clr_req = 1'b0;
  endtask

  task automatic start_xfer(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] n);
    @(negedge clk);
    base_addr = b;
    num_words = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < max_cyc) begin
      @(negedge clk);
      n++;
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, mem_read_en, tx_start} !== 4'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got busy/done/rd/txs=%b expected 0000", {busy, done, mem_read_en, tx_start});
    end
    checks++;
    if (mem_addr !== '0 || tx_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_data: got mem_addr=%h tx_data=%h expected 0/0", mem_addr, tx_data);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    bit ok;
    mem[5] = 10'h2A5;
    clear_logs();
    start_xfer(10'd5, 10'd1);
    wait_done(200, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL single_timeout: done not seen, expected within 200 cycles"); end
    checks++;
    if (rd_addrs.size() != 1 || rd_addrs[0] !== 10'd5) begin
      failures++;
      $display("FAIL single_read: got %0d reads, expected 1 at 005", rd_addrs.size());
    end
    checks++;
    if (tx_bytes.size() != 2 || tx_bytes[0] !== 8'hA5 || tx_bytes[1] !== 8'h02) begin
      failures++;
      $display("FAIL single_bytes: got %0d bytes %p expected A5 02", tx_bytes.size(), tx_bytes);
    end
    checks++;
    if (first_tx_cyc - start_cyc != 3) begin
      failures++;
      $display("FAIL single_latency: got %0d cycles expected 3", first_tx_cyc - start_cyc);
    end
    checks++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_done: got done_cnt=%0d busy=%b expected 1/0", done_cnt, busy);
    end
  endtask

  task automatic test_multi();
    bit ok;
    logic [7:0] exp_b [6] = '{8'h01, 8'h00, 8'hFF, 8'h03, 8'h55, 8'h01};
    mem[0] = 10'h001;
    mem[1] = 10'h3FF;
    mem[2] = 10'h155;
    clear_logs();
    start_xfer(10'd0, 10'd3);
    wait_done(300, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL multi_timeout: done not seen, expected within 300 cycles"); end
    checks++;
    if (tx_bytes.size() != 6) begin
      failures++;
      $display("FAIL multi_count: got %0d bytes expected 6", tx_bytes.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (tx_bytes[i] !== exp_b[i]) begin
          failures++;
          $display("FAIL multi_byte%0d: got %h expected %h", i, tx_bytes[i], exp_b[i]);
        end
      end
    end
    checks++;
    if (rd_addrs.size() != 3 || rd_addrs[2] !== 10'd2 || done_cnt != 1) begin
      failures++;
      $display("FAIL multi_reads: got reads=%0d done=%0d expected 3/1", rd_addrs.size(), done_cnt);
    end
    checks++;
    if (overlap_err != 0 || stable_err != 0) begin
      failures++;
      $display("FAIL multi_uart_proto: got overlap=%0d unstable=%0d expected 0/0", overlap_err, stable_err);
    end
  endtask

  task automatic test_zero();
    bit ok;
    clear_logs();
    start_xfer(10'd7, 10'd0);
    wait_done(20, ok);
    checks++;
    if (!ok || done_cyc - start_cyc != 2) begin
      failures++;
      $display("FAIL zero_done_latency: got ok=%0b latency=%0d expected 1/2", ok, done_cyc - start_cyc);
    end
    checks++;
    if (rd_addrs.size() != 0 || tx_bytes.size() != 0) begin
      failures++;
      $display("FAIL zero_activity: got reads=%0d bytes=%0d expected 0/0", rd_addrs.size(), tx_bytes.size());
    end
    checks++;
    if (busy_cnt != 1 || done_cnt != 1) begin
      failures++;
      $display("FAIL zero_busy: got busy_cycles=%0d done=%0d expected 1/1", busy_cnt, done_cnt);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    mem[1023] = 10'h123;
    mem[0]    = 10'h0AB;
    clear_logs();
    start_xfer(10'h3FF, 10'd2);
    wait_done(300, ok);
    checks++;
    if (!ok || rd_addrs.size() != 2 || rd_addrs[0] !== 10'h3FF || rd_addrs[1] !== 10'h000) begin
      failures++;
      $display("FAIL wrap_addrs: got ok=%0b reads=%p expected 3ff 000", ok, rd_addrs);
    end
    checks++;
    if (tx_bytes.size() != 4 || tx_bytes[0] !== 8'h23 || tx_bytes[1] !== 8'h01 ||
        tx_bytes[2] !== 8'hAB || tx_bytes[3] !== 8'h00) begin
      failures++;
      $display("FAIL wrap_bytes: got %p expected 23 01 ab 00", tx_bytes);
    end
  endtask

  task automatic test_ignore();
    bit ok;
    mem[10] = 10'h2C3;
    mem[11] = 10'h018;
    mem[40] = 10'h3EE;
    clear_logs();
    @(negedge clk);
    base_addr = 10'd10;
    num_words = 10'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    repeat (3) @(negedge clk);
    base_addr = 10'd40;
    num_words = 10'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(300, ok);
    checks++;
    if (!ok || rd_addrs.size() != 2 || rd_addrs[0] !== 10'd10 || rd_addrs[1] !== 10'd11) begin
      failures++;
      $display("FAIL ignore_reads: got ok=%0b reads=%p expected 00a 00b", ok, rd_addrs);
    end
    checks++;
    if (tx_bytes.size() != 4 || tx_bytes[0] !== 8'hC3 || tx_bytes[1] !== 8'h02 ||
        tx_bytes[2] !== 8'h18 || tx_bytes[3] !== 8'h00) begin
      failures++;
      $display("FAIL ignore_bytes: got %p expected c3 02 18 00", tx_bytes);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done_cnt != 1) begin
      failures++;
      $display("FAIL ignore_no_queue: got busy=%b done=%0d expected 0/1", busy, done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n = 0;
    for (int i = 0; i < 4; i++) mem[20 + i] = DATA_W'(10'h100 + i);
    clear_logs();
    start_xfer(10'd20, 10'd4);
    while (tx_bytes.size() < 4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tx_bytes.size() != 4) begin
      failures++;
      $display("FAIL rstmid_reach: got %0d bytes expected 4 before reset", tx_bytes.size());
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, mem_read_en, tx_start} !== 4'b0 || mem_addr !== '0 || tx_data !== 8'h00) begin
      failures++;
      $display("FAIL rstmid_outputs: got ctrl=%b addr=%h data=%h expected 0", {busy, done, mem_read_en, tx_start}, mem_addr, tx_data);
    end
    rst = 1'b0;
    repeat (2 * UART_DLY) @(negedge clk);
    clear_logs();
    start_xfer(10'd20, 10'd4);
    wait_done(500, ok);
    checks++;
    if (!ok || rd_addrs.size() != 4 || rd_addrs[0] !== 10'd20 || rd_addrs[3] !== 10'd23) begin
      failures++;
      $display("FAIL rstmid_restart: got ok=%0b reads=%p expected 014..017", ok, rd_addrs);
    end
    checks++;
    if (tx_bytes.size() != 8 || tx_bytes[0] !== 8'h00 || tx_bytes[1] !== 8'h01 || tx_bytes[6] !== 8'h03) begin
      failures++;
      $display("FAIL rstmid_bytes: got %p expected 00 01 01 01 02 01 03 01", tx_bytes);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    test_reset();
    test_single();
    test_multi();
    test_zero();
    test_wrap();
    test_ignore();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
